// File: rtl/mem_io_bridge_pkg.sv
// Shared constants for the core memory bridge: I/O page, register offsets and widths.
// Also holds the offset-to-register decode used by the bridge.
package mem_io_pkg;

  localparam logic [7:0] IO_PAGE     = 8'hFF;
  localparam logic [7:0] OFF_LED     = 8'h00;
  localparam logic [7:0] OFF_SW      = 8'h01;
  localparam logic [7:0] OFF_BTN_EVT = 8'h02;
  localparam logic [7:0] OFF_TICKS   = 8'h03;

  localparam int LED_W  = 10;
  localparam int SW_W   = 10;
  localparam int BTN_N  = 4;
  localparam int TICK_W = 16;

  typedef enum logic [2:0] {
    REG_LED     = 3'd0,
    REG_SW      = 3'd1,
    REG_BTN_EVT = 3'd2,
    REG_TICKS   = 3'd3,
    REG_NONE    = 3'd4
  } io_reg_e;

  function automatic io_reg_e decode_reg(input logic [7:0] off);
    io_reg_e r;
    case (off)
      OFF_LED:     r = REG_LED;
      OFF_SW:      r = REG_SW;
      OFF_BTN_EVT: r = REG_BTN_EVT;
      OFF_TICKS:   r = REG_TICKS;
      default:     r = REG_NONE;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_io_bridge_btn_debounce.sv
// One push-button channel: invert + two-flop sync, debounce to an accepted level,
// and a one-cycle press pulse on each accepted released->pressed change.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 500_000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic press
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic             level;
  logic             differ;
  logic             accept;
  logic [CNT_W-1:0] cnt;

  assign differ = (sync2 != level);
  assign accept = differ && (cnt == CNT_LAST);

  // Synchroniser on the inverted (pressed = 1) button level.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= ~btn_raw;
      sync2 <= sync1;
    end
  end

  // A disagreeing run must last DEBOUNCE_CYCLES samples; any agreeing sample restarts it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt   <= '0;
      level <= 1'b0;
      press <= 1'b0;
    end else begin
      press <= accept & sync2;
      if (accept) begin
        level <= sync2;
        cnt   <= '0;
      end else if (differ) begin
        cnt <= cnt + 1'b1;
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/mem_io_bridge.sv
// Decodes core memory accesses into block-RAM or the 0xFFxx I/O page (LED, SW,
// BTN_EVT, TICKS); both targets return read data one cycle after rd_en.
module mem_io_bridge
  import mem_io_pkg::*;
#(
  parameter int ADDR_W          = 16,
  parameter int DATA_W          = 16,
  parameter int CLK_HZ          = 50_000_000,
  parameter int TICK_HZ         = 1000,
  parameter int DEBOUNCE_CYCLES = 500_000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_en,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_din,
  output logic              bram_we,
  input  logic [DATA_W-1:0] bram_dout,
  input  logic [SW_W-1:0]   sw_in,
  input  logic [BTN_N-1:0]  btn_in,
  output logic [LED_W-1:0]  led_out
);

  localparam int PRESC_MAX = CLK_HZ / TICK_HZ - 1;
  localparam int PRESC_W   = (PRESC_MAX > 0) ? $clog2(PRESC_MAX + 1) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(PRESC_MAX);

  logic               io_sel;
  io_reg_e            io_reg;
  logic               io_wr;
  logic               io_rd;
  logic               evt_clr;
  logic               ticks_clr;
  logic               tick_wrap;
  logic [LED_W-1:0]   led;
  logic [SW_W-1:0]    sw_sync1;
  logic [SW_W-1:0]    sw_sync2;
  logic [BTN_N-1:0]   btn_press;
  logic [BTN_N-1:0]   btn_evt;
  logic [TICK_W-1:0]  ticks;
  logic [PRESC_W-1:0] presc;
  logic [DATA_W-1:0]  io_rd_val;
  logic [DATA_W-1:0]  io_rd_q;
  logic               rd_is_io;

  assign io_sel    = (addr[ADDR_W-1 -: 8] == IO_PAGE);
  assign io_reg    = decode_reg(addr[7:0]);
  assign io_wr     = wr_en & io_sel;
  assign io_rd     = rd_en & io_sel;
  assign evt_clr   = io_rd && (io_reg == REG_BTN_EVT);
  assign ticks_clr = io_wr && (io_reg == REG_TICKS);
  assign tick_wrap = (presc == PRESC_LAST);

  assign bram_addr = addr;
  assign bram_din  = wr_data;
  assign bram_we   = wr_en & ~io_sel;
  assign led_out   = led;
  assign rd_data   = rd_is_io ? io_rd_q : bram_dout;

  for (genvar i = 0; i < BTN_N; i++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk    (clk),
      .reset  (reset),
      .btn_raw(btn_in[i]),
      .press  (btn_press[i])
    );
  end

  // I/O read mux; unused bits and unmapped offsets read as zero.
  always_comb begin
    io_rd_val = '0;
    case (io_reg)
      REG_LED:     io_rd_val[LED_W-1:0]  = led;
      REG_SW:      io_rd_val[SW_W-1:0]   = sw_sync2;
      REG_BTN_EVT: io_rd_val[BTN_N-1:0]  = btn_evt;
      REG_TICKS:   io_rd_val[TICK_W-1:0] = ticks;
      default:     io_rd_val             = '0;
    endcase
  end

  // Read-source select and I/O read capture. Resetting to the I/O path makes rd_data 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_is_io <= 1'b1;
      io_rd_q  <= '0;
    end else begin
      if (rd_en) begin
        rd_is_io <= io_sel;
      end
      if (io_rd) begin
        io_rd_q <= io_rd_val;
      end
    end
  end

  // LED register and switch synchroniser.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      led      <= '0;
      sw_sync1 <= '0;
      sw_sync2 <= '0;
    end else begin
      sw_sync1 <= sw_in;
      sw_sync2 <= sw_sync1;
      if (io_wr && (io_reg == REG_LED)) begin
        led <= wr_data[LED_W-1:0];
      end
    end
  end

  // Sticky press flags: a press landing with a read-clear wins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      btn_evt <= '0;
    end else begin
      btn_evt <= (btn_evt & ~{BTN_N{evt_clr}}) | btn_press;
    end
  end

  // Prescaler and millisecond tick counter; a clearing write beats a same-cycle increment.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc <= '0;
      ticks <= '0;
    end else begin
      presc <= tick_wrap ? '0 : presc + 1'b1;
      if (ticks_clr) begin
        ticks <= '0;
      end else if (tick_wrap) begin
        ticks <= ticks + 1'b1;
      end
    end
  end

endmodule
